// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler
//   Shares one external FP adder between two requesters. Round-robin grant,
//   one-cycle launch pulse to the adder, bounded wait for the result, then a
//   held response until the consumer takes it. No arithmetic is done here:
//   the response is the adder result bit-exact, or a quiet-NaN on timeout.
//
// Ports
//   clock, reset              sole clock; async active-high reset
//   reqN_valid/ready/a/b      requester N operand pair handshake (N = 0,1)
//   dp_start, dp_a, dp_b      launch pulse and operands to the shared adder
//   dp_done, dp_sum           adder result strobe and value
//   rsp_valid/ready           response handshake
//   rsp_sum, rsp_id, rsp_err  result, owning requester, timeout flag
//   busy                      high whenever an operation is in flight
module fp_add_scheduler #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        dp_start,
    output logic [31:0] dp_a,
    output logic [31:0] dp_b,
    input  logic        dp_done,
    input  logic [31:0] dp_sum,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_sum,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic        busy
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fp_add_scheduler: TIMEOUT must be 2..255");
    end

    localparam logic [7:0]  TLIM    = 8'(TIMEOUT - 1);
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        id;
    } op_t;

    state_t          state, state_nxt;
    op_t             op;
    logic [7:0]      timer;
    logic            last_gnt;      // id of the most recent grant
    logic [1:0]      vld;
    logic [1:0][31:0] in_a, in_b;
    logic [1:0]      arb;           // round-robin winner, independent of state
    logic [1:0]      gnt;           // arb qualified by IDLE
    logic            gid;

    assign vld  = {req1_valid, req0_valid};
    assign in_a = {req1_a, req0_a};
    assign in_b = {req1_b, req0_b};

    // Tie goes to whoever did not win last time.
    assign arb[0] = vld[0] & (~vld[1] | last_gnt);
    assign arb[1] = vld[1] & (~vld[0] | ~last_gnt);
    assign gid    = gnt[1];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        gnt       = 2'b00;
        dp_start  = 1'b0;
        case (state)
            IDLE: begin
                // Ready is combinational; keep it low while reset is held so
                // a requester never sees a handshake that cannot complete.
                if (!reset && |vld) begin
                    gnt       = arb;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                dp_start  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // dp_done wins over a simultaneous timeout.
                if (dp_done || timer == TLIM) state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);
    assign dp_a       = (state == IDLE) ? 32'h0 : op.a;
    assign dp_b       = (state == IDLE) ? 32'h0 : op.b;
    assign rsp_id     = op.id;

    // ------------------------------------------------------------------
    // Operand latch, arbitration pointer, timer, response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op       <= '0;
            last_gnt <= 1'b1;
            timer    <= 8'd0;
            rsp_sum  <= 32'h0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        op       <= '{a: in_a[gid], b: in_b[gid], id: gid};
                        last_gnt <= gid;
                    end
                end
                ISSUE: timer <= 8'd0;
                WAIT: begin
                    if (dp_done) begin
                        rsp_sum <= dp_sum;
                        rsp_err <= 1'b0;
                    end else if (timer == TLIM) begin
                        rsp_sum <= QNAN;
                        rsp_err <= 1'b1;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed checks plus a randomized soak for fp_add_scheduler. A small
// adder model answers dp_start after a chosen latency; expected responses
// come from a queue of accepted pairs and the round-robin rule.
module tb_fp_add_scheduler;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        dp_start, dp_done;
    logic [31:0] dp_a, dp_b, dp_sum;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [31:0] rsp_sum;

    // adder model controls
    logic        ad_en = 1'b0, ad_rand = 1'b0, ad_done;
    int          ad_lat = 2;
    logic [31:0] ad_sum;
    // manual dp_done injection
    logic        man_done;
    logic [31:0] man_sum;

    assign dp_done = ad_done | man_done;
    assign dp_sum  = man_done ? man_sum : ad_sum;

    int n_cmp = 0;
    int n_err = 0;

    fp_add_scheduler #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b), .dp_done(dp_done), .dp_sum(dp_sum),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clock = ~clock;

    // Adder behaviour: any deterministic function of the operands will do,
    // since the scheduler must pass it through untouched.
    function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return (a + b) ^ 32'h0F0F_00F0;
    endfunction

    initial begin : adder
        logic [31:0] a, b;
        int lat;
        ad_done = 1'b0;
        ad_sum  = 32'h0;
        forever begin
            @(negedge clock);
            ad_done = 1'b0;
            #2;
            if (dp_start && ad_en) begin
                a   = dp_a;
                b   = dp_b;
                lat = ad_rand ? int'($urandom_range(1, TO - 2)) : ad_lat;
                repeat (lat) @(negedge clock);
                ad_done = 1'b1;
                ad_sum  = fmodel(a, b);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed hang, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0; man_done = 0;
        ad_en = 0; ad_rand = 0;
        repeat (20) @(negedge clock);   // flush any adder pulse still pending
        reset = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        req0_valid = 0; req1_valid = 0; man_done = 0;
        while (busy && n < 60) begin
            @(negedge clock); #1;
            n++;
        end
        chk("drain_idle", busy, 0);
        rsp_ready = 1'b0;
    endtask

    // Single req granted at N; result (or timeout) checked at N+18.
    task automatic tmo_case(input string tag, input int lat, input logic use_adder,
                            input logic id, input logic exp_err);
        logic [31:0] a, b, exp_sum;
        do_reset();
        ad_en = use_adder; ad_lat = lat;
        a = $urandom; b = $urandom;
        exp_sum = exp_err ? 32'h7FC0_0000 : fmodel(a, b);
        @(negedge clock);
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; end
        #1;
        chk({tag, "_grant"}, id ? req1_ready : req0_ready, 1);
        for (int i = 1; i <= 19; i++) begin
            @(negedge clock);
            req0_valid = 0; req1_valid = 0;
            #1;
            if (i == 17) chk({tag, "_early"}, rsp_valid, 0);
            if (i >= 18) begin
                chk({tag, "_valid"}, rsp_valid, 1);
                chk({tag, "_sum"}, rsp_sum, exp_sum);
                chk({tag, "_err"}, rsp_err, exp_err);
                chk({tag, "_id"}, rsp_id, id);
                chk({tag, "_dpa"}, dp_a, a);
            end
        end
        drain();
    endtask

    typedef struct { logic id; logic [31:0] a; logic [31:0] b; } txn_t;

    initial begin : main
        logic [31:0] a0, b0, bp_sum;
        int gcount, n;
        logic prev_g;
        txn_t q[$];
        txn_t t;
        logic [1:0] vld;
        logic [1:0][31:0] sa, sb;
        logic last, win;
        int nresp;

        reset = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 0; man_done = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; man_sum = 0;

        // ---------------- reset state ----------------
        @(negedge clock);
        req0_valid = 1; req1_valid = 1; req0_a = 32'hDEAD_BEEF; req1_b = 32'h1234_5678;
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", dp_start, 0);
        chk("rst_dpa", dp_a, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_sum", rsp_sum, 0);
        chk("rst_err", rsp_err, 0);

        // ---------------- single request ----------------
        do_reset();
        ad_en = 1; ad_lat = 2;
        @(negedge clock);
        req0_valid = 1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000;
        #1;
        chk("t1_ready0", req0_ready, 1);
        chk("t1_ready1", req1_ready, 0);
        chk("t1_start_n", dp_start, 0);
        @(negedge clock);
        req0_valid = 0; req0_a = 32'h1111_1111; req0_b = 32'h2222_2222;
        #1;
        chk("t1_start", dp_start, 1);
        chk("t1_dpa", dp_a, 32'h3F80_0000);
        chk("t1_dpb", dp_b, 32'h4000_0000);
        chk("t1_busy", busy, 1);
        @(negedge clock); #1;
        chk("t1_start_once", dp_start, 0);
        chk("t1_rspv_n2", rsp_valid, 0);
        @(negedge clock); #1;
        chk("t1_rspv_n3", rsp_valid, 0);
        @(negedge clock);
        rsp_ready = 1;
        #1;
        chk("t1_rspv", rsp_valid, 1);
        chk("t1_sum", rsp_sum, 32'h4040_0000);
        chk("t1_id", rsp_id, 0);
        chk("t1_err", rsp_err, 0);
        @(negedge clock);
        rsp_ready = 0;
        #1;
        chk("t1_idle", busy, 0);
        chk("t1_dpa_idle", dp_a, 0);

        // ---------------- contention ----------------
        @(negedge clock);
        reset = 1;
        req0_valid = 1; req1_valid = 1;
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        rsp_ready = 1; ad_en = 1; ad_lat = 1;
        repeat (20) @(negedge clock);
        reset = 0;
        gcount = 0; prev_g = 0; n = 0;
        while (gcount < 4 && n < 40) begin
            #1;
            if (prev_g) chk("t2_pulse", {31'b0, req0_ready | req1_ready}, 0);
            chk("t2_excl", {31'b0, req0_ready & req1_ready}, 0);
            prev_g = req0_ready | req1_ready;
            if (prev_g) begin
                chk("t2_order", req1_ready, gcount[0]);
                gcount++;
            end
            @(negedge clock);
            n++;
        end
        chk("t2_count", gcount, 4);
        drain();

        // ---------------- timeout ----------------
        tmo_case("t3_tmo", 0, 1'b0, 1'b1, 1'b1);
        tmo_case("t3_edge", TO, 1'b1, 1'b0, 1'b0);    // done at the limit cycle
        tmo_case("t3_late", TO + 1, 1'b1, 1'b0, 1'b1); // done arrives in RESP

        // ---------------- backpressure ----------------
        do_reset();
        ad_en = 1; ad_lat = 1;
        a0 = $urandom; b0 = $urandom;
        @(negedge clock);
        req0_valid = 1; req0_a = a0; req0_b = b0;
        #1;
        chk("t4_grant", req0_ready, 1);
        @(negedge clock);
        req0_valid = 0;
        n = 0;
        #1;
        while (!rsp_valid && n < 30) begin
            @(negedge clock); #1;
            n++;
        end
        chk("t4_reach", rsp_valid, 1);
        ad_en = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            rsp_ready = 0;
            req0_valid = 1; req1_valid = 1;
            req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
            man_done = 1'($urandom); bp_sum = $urandom; man_sum = bp_sum;
            #1;
            chk("t4_valid", rsp_valid, 1);
            chk("t4_sum", rsp_sum, fmodel(a0, b0));
            chk("t4_id", rsp_id, 0);
            chk("t4_err", rsp_err, 0);
            chk("t4_busy", busy, 1);
            chk("t4_rdy", {30'b0, req1_ready, req0_ready}, 0);
            chk("t4_dpa", dp_a, a0);
        end
        @(negedge clock);
        rsp_ready = 1; man_done = 0; ad_en = 1;
        #1;
        chk("t4_xfer", rsp_valid, 1);
        chk("t4_nogrant", {30'b0, req1_ready, req0_ready}, 0);
        @(negedge clock);
        rsp_ready = 0;
        #1;
        chk("t4_idle", busy, 0);
        chk("t4_rr", {30'b0, req1_ready, req0_ready}, 2'b10);
        drain();

        // ---------------- reset in WAIT ----------------
        do_reset();
        @(negedge clock);
        req0_valid = 1; req0_a = $urandom; req0_b = $urandom;
        #1;
        chk("t5_grant", req0_ready, 1);
        @(negedge clock);
        req0_valid = 0;
        #1;
        chk("t5_start", dp_start, 1);
        repeat (3) @(negedge clock);
        reset = 1; req0_valid = 1; req1_valid = 1;
        #1;
        chk("t5_rdy", {30'b0, req1_ready, req0_ready}, 0);
        chk("t5_start0", dp_start, 0);
        chk("t5_dpa", dp_a, 0);
        chk("t5_dpb", dp_b, 0);
        chk("t5_rspv", rsp_valid, 0);
        chk("t5_sum", rsp_sum, 0);
        chk("t5_id", rsp_id, 0);
        chk("t5_err", rsp_err, 0);
        chk("t5_busy", busy, 0);
        @(negedge clock);
        reset = 0; req0_valid = 0; req1_valid = 0;
        man_done = 1; man_sum = $urandom;
        #1;
        chk("t5_ign_v", rsp_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            man_done = 0;
            #1;
            chk("t5_quiet_v", rsp_valid, 0);
            chk("t5_quiet_b", busy, 0);
        end
        @(negedge clock);
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("t5_tie", {30'b0, req1_ready, req0_ready}, 2'b01);
        ad_en = 1; ad_lat = 1;
        @(negedge clock);
        drain();

        // ---------------- random soak ----------------
        do_reset();
        ad_en = 1; ad_rand = 1;
        last = 1'b1; vld = 2'b00; nresp = 0; n = 0;
        sa = '0; sb = '0;
        while (nresp < 400 && n < 20000) begin
            @(negedge clock);
            n++;
            for (int r = 0; r < 2; r++) begin
                if (!vld[r] && $urandom_range(0, 2) == 0) begin
                    vld[r] = 1'b1;
                    sa[r] = $urandom;
                    sb[r] = $urandom;
                end
            end
            req0_valid = vld[0]; req0_a = sa[0]; req0_b = sb[0];
            req1_valid = vld[1]; req1_a = sa[1]; req1_b = sb[1];
            rsp_ready = 1'($urandom);
            #1;
            if (req0_ready & req1_ready) chk("soak_excl", 2'b11, 2'b01);
            if (req0_ready & ~vld[0]) chk("soak_rdy0_v", req0_ready, 0);
            if (req1_ready & ~vld[1]) chk("soak_rdy1_v", req1_ready, 0);
            if (req0_ready | req1_ready) begin
                win = (vld[0] && vld[1]) ? ~last : ~vld[0];
                chk("soak_arb", req1_ready, win);
                last = win;
                t.id = win; t.a = sa[win]; t.b = sb[win];
                q.push_back(t);
                vld[win] = 1'b0;
            end
            if (dp_start) begin
                chk("soak_start_q", {31'b0, q.size() > 0}, 1);
                if (q.size() > 0) begin
                    chk("soak_dpa", dp_a, q[$].a);
                    chk("soak_dpb", dp_b, q[$].b);
                end
            end
            if (rsp_valid && rsp_ready) begin
                chk("soak_rsp_q", {31'b0, q.size() > 0}, 1);
                if (q.size() > 0) begin
                    t = q.pop_front();
                    chk("soak_id", rsp_id, t.id);
                    chk("soak_sum", rsp_sum, fmodel(t.a, t.b));
                    chk("soak_err", rsp_err, 0);
                end
                nresp++;
            end
        end
        chk("soak_count", nresp, 400);
        chk("soak_left", q.size(), 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
